// File: rtl/piso_pkg.sv
// Shared types and frame-size helpers for the PISO serializer.
// The PISO_PARITY_EN macro adds a trailing even-parity bit to every frame.
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // The parity bit, when enabled, is one extra slot at the end of the frame.
  function automatic int frame_bits(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer: synchronous clear, enabled increment,
// and a flag marking the final bit slot of the frame.
module piso_bit_counter #(
  parameter int CNT_W    = 3,
  parameter int LAST_VAL = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_VAL);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == LAST_CNT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, MSB first, valid/ready load handshake.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int FRAME_BITS = frame_bits(WIDTH);
  localparam int CNT_W      = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             done_q, done_d;
  logic             cnt_clear, cnt_inc, last_bit;
  logic             take_word;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  piso_bit_counter #(
    .CNT_W    (CNT_W),
    .LAST_VAL (FRAME_BITS - 1)
  ) u_bit_counter (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .last  (last_bit)
  );

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    done_d     = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    out        = 1'b0;
    take_word  = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        take_word  = load_valid;
      end
      SHIFT: begin
        out_valid = 1'b1;
`ifdef PISO_PARITY_EN
        out = last_bit ? parity_q : sreg_q[WIDTH-1];
`else
        out = sreg_q[WIDTH-1];
`endif
        if (enable) begin
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          if (last_bit) begin
            // Final slot: a waiting word loads on this same edge, no idle gap.
            done_d     = 1'b1;
            load_ready = 1'b1;
            take_word  = load_valid;
            cnt_clear  = 1'b1;
            state_d    = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take_word) begin
      sreg_d    = load_data;
      cnt_clear = 1'b1;
      state_d   = SHIFT;
`ifdef PISO_PARITY_EN
      parity_d  = ^load_data;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      done_q   <= done_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: queue-based frame model checked
// every cycle, directed frames with literal expectations, then random traffic.
module tb_piso_serializer;

  localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
  localparam int FB = WIDTH + 1;
`else
  localparam int FB = WIDTH;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             load_ready, out, out_valid, done;

  int n_tests = 0;
  int n_fail  = 0;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .out        (out),
    .out_valid  (out_valid),
    .done       (done)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: queue of frame bits still to be sent; head is what the line shows.
  bit   exp_q[$];
  logic exp_done = 1'b0;
  bit   chk_en = 1'b0;

  always @(posedge clock) begin
    bit rdy;
    if (reset) begin
      exp_q.delete();
      exp_done = 1'b0;
    end else begin
      rdy      = (exp_q.size() == 0) || (exp_q.size() == 1 && enable);
      exp_done = (exp_q.size() == 1) && enable;
      if (enable && exp_q.size() > 0) void'(exp_q.pop_front());
      if (rdy && load_valid) begin
        for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(load_data[i]);
`ifdef PISO_PARITY_EN
        exp_q.push_back(^load_data);
`endif
      end
    end
  end

  // Receiver-side monitor state
  logic [15:0] rx = '0;
  int rx_n = 0;
  int done_cnt = 0;
  int done_gap = 0;
  int last_done_cyc = 0;
  int cyc = 0;

  always @(negedge clock) begin
    cyc++;
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      check("out", 32'(out), 32'((exp_q.size() > 0) ? exp_q[0] : 1'b0));
      check("done", 32'(done), 32'(exp_done));
      check("load_ready", 32'(load_ready),
            32'((exp_q.size() == 0) || (exp_q.size() == 1 && enable)));
    end
    if (out_valid === 1'b1 && enable && !reset) begin
      rx = {rx[14:0], out};
      rx_n++;
    end
    if (done === 1'b1) begin
      if (done_cnt > 0) done_gap = cyc - last_done_cyc;
      last_done_cyc = cyc;
      done_cnt++;
    end
  end

  task automatic clear_mon();
    rx = '0;
    rx_n = 0;
    done_cnt = 0;
    done_gap = 0;
  endtask

  // Offers a word and returns just after the posedge that accepted it.
  task automatic send_word(input logic [WIDTH-1:0] data);
    logic r;
    int   k;
    load_valid = 1'b1;
    load_data  = data;
    k = 0;
    do begin
      @(negedge clock);
      r = load_ready;
      @(posedge clock);
      #1;
      k++;
    end while (!r && k < 50);
    if (!r) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: load_ready stayed 0 for word %0h", data);
    end
  endtask

  function automatic logic [31:0] mask(input int n, input logic [15:0] v);
    return 32'(v) & ((32'd1 << n) - 32'd1);
  endfunction

  logic acc;

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clock);
    #1;
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    @(posedge clock);
    #1;

    // Frame 1011 with enable held high
    clear_mon();
    enable = 1'b1;
    send_word(4'b1011);
    load_valid = 1'b0;
    repeat (FB) @(posedge clock);
    #1;
    @(negedge clock);
    #1;
    check("t1_done", 32'(done), 32'd1);
    check("t1_rx_n", 32'(rx_n), 32'(FB));
`ifdef PISO_PARITY_EN
    check("t1_rx", mask(FB, rx), 32'b10111);
`else
    check("t1_rx", mask(FB, rx), 32'b1011);
`endif
    @(posedge clock);
    #1;

    // Frame 0110 with enable toggling
    clear_mon();
    send_word(4'b0110);
    load_valid = 1'b0;
    for (int i = 0; i < 2 * FB; i++) begin
      enable = (i % 2 == 0);
      @(posedge clock);
      #1;
    end
    enable = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("t2_rx_n", 32'(rx_n), 32'(FB));
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
`ifdef PISO_PARITY_EN
    check("t2_rx", mask(FB, rx), 32'b01100);
`else
    check("t2_rx", mask(FB, rx), 32'b0110);
`endif

    // Back-to-back 1100 then 0011
    clear_mon();
    send_word(4'b1100);
    send_word(4'b0011);
    load_valid = 1'b0;
    repeat (FB + 2) @(posedge clock);
    #1;
    check("t3_rx_n", 32'(rx_n), 32'(2 * FB));
    check("t3_done_cnt", 32'(done_cnt), 32'd2);
    check("t3_done_gap", 32'(done_gap), 32'(FB));
`ifdef PISO_PARITY_EN
    check("t3_rx", mask(2 * FB, rx), 32'b1100000110);
`else
    check("t3_rx", mask(2 * FB, rx), 32'b11000011);
`endif

    // Word offered mid-frame waits for the last-bit edge
    clear_mon();
    send_word(4'b1010);
    load_valid = 1'b0;
    @(posedge clock);
    #1;
    load_valid = 1'b1;
    load_data  = 4'b0101;
    @(negedge clock);
    #1;
    check("t4_mid_ready", 32'(load_ready), 32'd0);
    send_word(4'b0101);
    load_valid = 1'b0;
    repeat (FB + 2) @(posedge clock);
    #1;
    check("t4_rx_n", 32'(rx_n), 32'(2 * FB));
`ifdef PISO_PARITY_EN
    check("t4_rx", mask(2 * FB, rx), 32'b1010001010);
`else
    check("t4_rx", mask(2 * FB, rx), 32'b10100101);
`endif

    // Reset after two bits of 1111
    clear_mon();
    send_word(4'b1111);
    load_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("t5_out", 32'(out), 32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_load_ready", 32'(load_ready), 32'd1);
    repeat (FB + 2) @(posedge clock);
    #1;
    check("t5_no_done", 32'(done_cnt), 32'd0);

    // Random traffic honouring the hold-until-accepted rule
    acc = 1'b0;
    load_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!load_valid || acc) begin
        load_valid = ($urandom_range(0, 2) != 0);
        load_data  = WIDTH'($urandom);
      end
      enable = ($urandom_range(0, 3) != 0);
      reset  = ($urandom_range(0, 199) == 0);
      @(negedge clock);
      acc = load_valid && load_ready && !reset;
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    load_valid = 1'b0;
    repeat (FB + 2) @(posedge clock);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
